// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with a 2-entry skid buffer, registered in_ready and misalignment flag.
// Define EXMEM_BRANCH_EN to resolve beq/bne in this stage; otherwise branch outputs are tied 0.
module ex_mem_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic [DATA_W-1:0] store_data,
  input  logic [REG_W-1:0]  write_reg,
  input  logic              ctl_regwrite,
  input  logic              ctl_memread,
  input  logic              ctl_memwrite,
  input  logic              ctl_memtoreg,
  input  logic              ctl_branch,
  input  logic              ctl_bne,
  input  logic [DATA_W-1:0] branch_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_store_data,
  output logic [REG_W-1:0]  out_write_reg,
  output logic              out_ctl_regwrite,
  output logic              out_ctl_memread,
  output logic              out_ctl_memwrite,
  output logic              out_ctl_memtoreg,
  output logic              out_misaligned,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_pc
);

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store_data;
    logic [REG_W-1:0]  write_reg;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic              memtoreg;
    logic              misaligned;
`ifdef EXMEM_BRANCH_EN
    logic              zero;
    logic              branch;
    logic              bne;
    logic [DATA_W-1:0] target;
`endif
  } entry_t;

  entry_t head_q, head_d, skid_q, skid_d, in_entry;
  logic   head_v_q, head_v_d, skid_v_q, skid_v_d, in_ready_q;
  logic   accept, issue;

  assign accept = in_valid & in_ready_q;
  assign issue  = head_v_q & out_ready;

  always_comb begin
    in_entry            = '0;
    in_entry.result     = alu_result;
    in_entry.store_data = store_data;
    in_entry.write_reg  = write_reg;
    in_entry.regwrite   = ctl_regwrite;
    in_entry.memread    = ctl_memread;
    in_entry.memwrite   = ctl_memwrite;
    in_entry.memtoreg   = ctl_memtoreg;
    in_entry.misaligned = (ctl_memread | ctl_memwrite) & (alu_result[1:0] != 2'b00);
`ifdef EXMEM_BRANCH_EN
    in_entry.zero       = alu_zero;
    in_entry.branch     = ctl_branch;
    in_entry.bne        = ctl_bne;
    in_entry.target     = branch_target;
`endif
  end

  always_comb begin
    head_v_d = head_v_q;
    skid_v_d = skid_v_q;
    head_d   = head_q;
    skid_d   = skid_q;
    if (flush) begin
      // Issue this cycle still reaches MEM; only held/incoming work is squashed.
      head_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (head_v_q && !issue) begin
      // Skid is necessarily empty whenever accept is possible.
      if (accept) begin
        skid_v_d = 1'b1;
        skid_d   = in_entry;
      end
    end else if (skid_v_q) begin
      head_v_d = 1'b1;
      head_d   = skid_q;
      skid_v_d = accept;
      if (accept) skid_d = in_entry;
    end else begin
      head_v_d = accept;
      if (accept) head_d = in_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_v_q   <= 1'b0;
      skid_v_q   <= 1'b0;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      head_v_q   <= head_v_d;
      skid_v_q   <= skid_v_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= ~skid_v_d;
    end
  end

  assign in_ready         = in_ready_q;
  assign out_valid        = head_v_q;
  assign out_result       = head_q.result;
  assign out_store_data   = head_q.store_data;
  assign out_write_reg    = head_q.write_reg;
  assign out_ctl_regwrite = head_q.regwrite;
  assign out_ctl_memread  = head_q.memread;
  assign out_ctl_memwrite = head_q.memwrite;
  assign out_ctl_memtoreg = head_q.memtoreg;
  assign out_misaligned   = head_q.misaligned;

`ifdef EXMEM_BRANCH_EN
  // Tied to issue so a stalled branch redirects exactly once, when MEM takes it.
  assign branch_taken = issue & head_q.branch & (head_q.zero ^ head_q.bne);
  assign branch_pc    = head_q.target;
`else
  logic unused_branch_inputs;
  assign unused_branch_inputs = ^{alu_zero, ctl_branch, ctl_bne, branch_target};
  assign branch_taken = 1'b0;
  assign branch_pc    = '0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed literal checks plus randomized traffic
// compared every cycle against a queue-based model of the stage.
module tb_ex_mem_stage;
`ifdef EXMEM_BRANCH_EN
  localparam bit BrEn = 1'b1;
`else
  localparam bit BrEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, alu_zero;
  logic [31:0] alu_result, store_data, branch_target, branch_pc;
  logic [4:0]  write_reg, out_write_reg;
  logic        ctl_regwrite, ctl_memread, ctl_memwrite, ctl_memtoreg, ctl_branch, ctl_bne;
  logic        out_valid, out_ready, out_ctl_regwrite, out_ctl_memread, out_ctl_memwrite;
  logic        out_ctl_memtoreg, out_misaligned, branch_taken;
  logic [31:0] out_result, out_store_data;

  always #5 clk = ~clk;

  ex_mem_stage #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .alu_zero(alu_zero), .store_data(store_data),
    .write_reg(write_reg), .ctl_regwrite(ctl_regwrite), .ctl_memread(ctl_memread),
    .ctl_memwrite(ctl_memwrite), .ctl_memtoreg(ctl_memtoreg), .ctl_branch(ctl_branch),
    .ctl_bne(ctl_bne), .branch_target(branch_target), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_store_data(out_store_data),
    .out_write_reg(out_write_reg), .out_ctl_regwrite(out_ctl_regwrite),
    .out_ctl_memread(out_ctl_memread), .out_ctl_memwrite(out_ctl_memwrite),
    .out_ctl_memtoreg(out_ctl_memtoreg), .out_misaligned(out_misaligned),
    .branch_taken(branch_taken), .branch_pc(branch_pc)
  );

  typedef struct {
    logic [31:0] res, sd, tgt;
    logic [4:0]  wr;
    logic        rw, mr, mw, mt, z, br, bne;
  } ent_t;

  ent_t q[$];
  bit   rdy_exp = 1'b0;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: stage is a FIFO of depth 2; in_ready next = fewer than 2 entries held next.
  always @(negedge clk) begin
    ent_t h, n;
    bit   issue, accept, taken;
    h = '{default: '0};
    chk("m_out_valid", out_valid, q.size() > 0);
    chk("m_in_ready", in_ready, rdy_exp);
    if (q.size() > 0) begin
      h = q[0];
      chk("m_result", out_result, h.res);
      chk("m_store_data", out_store_data, h.sd);
      chk("m_write_reg", out_write_reg, h.wr);
      chk("m_ctl", {out_ctl_regwrite, out_ctl_memread, out_ctl_memwrite, out_ctl_memtoreg},
          {h.rw, h.mr, h.mw, h.mt});
      chk("m_misaligned", out_misaligned, (h.mr || h.mw) && (h.res % 4 != 0));
    end
    issue  = (q.size() > 0) && out_ready;
    accept = in_valid && rdy_exp;
    taken  = BrEn && issue && h.br && (h.z != h.bne);
    chk("m_branch_taken", branch_taken, taken);
    if (taken) chk("m_branch_pc", branch_pc, h.tgt);
    if (!BrEn) chk("m_branch_pc_tied", branch_pc, 0);
    n = '{res: alu_result, sd: store_data, tgt: branch_target, wr: write_reg, rw: ctl_regwrite,
          mr: ctl_memread, mw: ctl_memwrite, mt: ctl_memtoreg, z: alu_zero, br: ctl_branch,
          bne: ctl_bne};
    if (!rst_n) begin
      q.delete();
      rdy_exp = 1'b0;
    end else if (flush) begin
      q.delete();
      rdy_exp = 1'b1;
    end else begin
      if (issue) void'(q.pop_front());
      if (accept) q.push_back(n);
      rdy_exp = q.size() < 2;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    flush = 0; in_valid = 0; out_ready = 0; alu_result = 0; alu_zero = 0; store_data = 0;
    write_reg = 0; ctl_regwrite = 0; ctl_memread = 0; ctl_memwrite = 0; ctl_memtoreg = 0;
    ctl_branch = 0; ctl_bne = 0; branch_target = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_branch_taken", branch_taken, 0);
    tick(); rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);
    // Pass-through
    tick(); idle(); in_valid = 1; alu_result = 5; write_reg = 3; ctl_regwrite = 1; out_ready = 1;
    tick(); in_valid = 0;
    @(negedge clk);
    chk("pass_valid", out_valid, 1);
    chk("pass_result", out_result, 5);
    chk("pass_wr", out_write_reg, 3);
    chk("pass_rw", out_ctl_regwrite, 1);
    tick();
    @(negedge clk);
    chk("pass_drained", out_valid, 0);
    // Backpressure
    tick(); idle(); in_valid = 1; alu_result = 32'h10;
    tick(); alu_result = 32'h20;
    tick(); in_valid = 0;
    @(negedge clk);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_hold_a0", out_result, 32'h10);
    tick();
    @(negedge clk);
    chk("bp_hold_a1", out_result, 32'h10);
    chk("bp_valid", out_valid, 1);
    tick(); out_ready = 1;
    @(negedge clk);
    chk("bp_a_out", out_result, 32'h10);
    tick();
    @(negedge clk);
    chk("bp_b_out", out_result, 32'h20);
    chk("bp_ready_back", in_ready, 1);
    tick();
    @(negedge clk);
    chk("bp_empty", out_valid, 0);
    // Flush
    tick(); idle(); in_valid = 1; alu_result = 32'h30;
    tick(); alu_result = 32'h34;
    tick(); alu_result = 32'hC; flush = 1;
    tick(); flush = 0; in_valid = 0;
    @(negedge clk);
    chk("fl_valid", out_valid, 0);
    chk("fl_ready", in_ready, 1);
    repeat (3) tick();
    @(negedge clk);
    chk("fl_no_c", out_valid, 0);
    // Branch
    tick(); idle(); out_ready = 1; in_valid = 1; ctl_branch = 1; alu_zero = 1;
    branch_target = 32'h40;
    tick(); in_valid = 0;
    @(negedge clk);
    chk("beq_taken", branch_taken, BrEn);
    chk("beq_pc", branch_pc, BrEn ? 32'h40 : 32'h0);
    tick();
    @(negedge clk);
    chk("beq_pulse_end", branch_taken, 0);
    tick(); in_valid = 1; ctl_bne = 1;
    tick(); in_valid = 0;
    @(negedge clk);
    chk("bne_not_taken", branch_taken, 0);
    tick(); out_ready = 0; in_valid = 1; ctl_bne = 0; branch_target = 32'h80;
    tick(); in_valid = 0;
    repeat (3) begin
      @(negedge clk);
      chk("br_stalled", branch_taken, 0);
      tick();
    end
    out_ready = 1;
    @(negedge clk);
    chk("br_issue", branch_taken, BrEn);
    chk("br_issue_pc", branch_pc, BrEn ? 32'h80 : 32'h0);
    tick();
    @(negedge clk);
    chk("br_once", branch_taken, 0);
    // Misaligned
    tick(); idle(); out_ready = 1; in_valid = 1; ctl_memwrite = 1; alu_result = 32'h102;
    tick(); alu_result = 32'h104;
    @(negedge clk);
    chk("mis_102", out_misaligned, 1);
    tick(); in_valid = 0;
    @(negedge clk);
    chk("mis_104", out_misaligned, 0);
    // Random traffic, checked by the model every cycle
    repeat (3000) begin
      tick();
      rst_n         = ($urandom_range(0, 199) != 0);
      flush         = ($urandom_range(0, 15) == 0);
      in_valid      = $urandom_range(0, 1);
      out_ready     = ($urandom_range(0, 3) != 0);
      alu_result    = $urandom;
      alu_zero      = $urandom_range(0, 1);
      store_data    = $urandom;
      write_reg     = 5'($urandom);
      ctl_regwrite  = $urandom_range(0, 1);
      ctl_memread   = $urandom_range(0, 1);
      ctl_memwrite  = $urandom_range(0, 1);
      ctl_memtoreg  = $urandom_range(0, 1);
      ctl_branch    = $urandom_range(0, 1);
      ctl_bne       = $urandom_range(0, 1);
      branch_target = $urandom;
    end
    tick(); idle(); rst_n = 1'b1; out_ready = 1;
    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
